// File: rtl/debounce_pkg.sv
// Shared state encoding for the per-channel debounce FSM.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, 4-state FSM and registered strobes.
// Optional long-press hold counter is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CNT    = 60000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (STABLE_CNT < 2 || SYNC_STAGES < 2 || LONG_CNT < 1 ||
      (STABLE_CNT >> CNT_W) != 0 || (LONG_CNT >> CNT_W) != 0) begin : g_bad_params
    $error("debounce_ch: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   clean_q, rise_q, fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO, STABLE_HI: begin
          if (s != clean_q) begin
            state_q <= (state_q == STABLE_LO) ? WAIT_HI : WAIT_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_HI, WAIT_LO: begin
          // Any revert to the accepted level throws the partial count away.
          if (s == clean_q) begin
            state_q <= clean_q ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            clean_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            state_q <= s ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CNT - 1);

  logic [CNT_W-1:0] hold_q;
  logic             long_q;

  // Saturation at LONG_MAX guarantees a single pulse per press.
  always_ff @(posedge clk_i) begin
    if (reset_i || !clean_q) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      if (hold_q != LONG_MAX) hold_q <= hold_q + CNT_ONE;
      long_q <= (hold_q == LONG_PRE);
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer top: wiring only, one debounce_ch per input bit.
// LONG is live only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CNT    = 60000
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [N_CH-1:0] RAW,
  output logic [N_CH-1:0] CLEAN,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL,
  output logic [N_CH-1:0] LONG
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_CNT   (LONG_CNT)
    ) u_ch (
      .clk_i  (CLK),
      .reset_i(reset),
      .raw_i  (RAW[i]),
      .clean_o(CLEAN[i]),
      .rise_o (RISE[i]),
      .fall_o (FALL[i]),
      .long_o (LONG[i])
    );
  end

endmodule
